gcd_engine: RTL and testbench

GCD_ENGINE -- requirements
Module: gcd_engine

---
 rtl/gcd_pkg.sv | 24 ++
 rtl/gcd_datapath.sv | 78 +++++++
 rtl/gcd_engine.sv | 122 ++++++++++++
 tb/tb_gcd_engine.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gcd_pkg.sv
// Shared definitions for the binary GCD engine.
// - gcd_state_e : FSM state encoding (idle, common-factor shift, reduce, done)
// - log2        : ceiling log2 (minimum 1), used to size the shared power-of-two counter k
package gcd_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StShift  = 2'd1,
    StReduce = 2'd2,
    StDone   = 2'd3
  } gcd_state_e;

  // Smallest r >= 1 with 2**r >= value. k never exceeds WIDTH-1, so
  // log2(WIDTH) bits always hold it.
  function automatic int unsigned log2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/gcd_datapath.sv
// Operand datapath for the binary (Stein) GCD engine.
// Holds the working operands A and B and the common power-of-two count k.
// Ports:
//   clk_i, rst_i     : clock, synchronous active-high reset
//   load_i           : load a_i/b_i into A/B and clear k
//   a_i, b_i         : operands captured on load
//   shift_i          : engine is in the shift phase (divide out common twos)
//   reduce_i         : engine is in the reduce phase
//   both_even_o      : A and B are both even
//   equal_o          : A equals B
//   gcd_o            : A << k, the final result once A == B
module gcd_datapath
  import gcd_pkg::*;
#(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  input  logic             shift_i,
  input  logic             reduce_i,
  output logic             both_even_o,
  output logic             equal_o,
  output logic [Width-1:0] gcd_o
);

  localparam int unsigned KW = log2(Width);
  localparam logic [KW-1:0] KOne = KW'(1);

  logic [Width-1:0] a_q, a_d;
  logic [Width-1:0] b_q, b_d;
  logic [KW-1:0]    k_q, k_d;

  assign both_even_o = ~a_q[0] & ~b_q[0];
  assign equal_o     = (a_q == b_q);
  assign gcd_o       = a_q << k_q;

  always_comb begin
    a_d = a_q;
    b_d = b_q;
    k_d = k_q;
    if (load_i) begin
      a_d = a_i;
      b_d = b_i;
      k_d = '0;
    end else if (shift_i && both_even_o) begin
      a_d = a_q >> 1;
      b_d = b_q >> 1;
      k_d = k_q + KOne;
    end else if (reduce_i && !equal_o) begin
      // Halving wins over subtraction; the subtract is always larger minus smaller.
      if (!a_q[0]) begin
        a_d = a_q >> 1;
      end else if (!b_q[0]) begin
        b_d = b_q >> 1;
      end else if (a_q > b_q) begin
        a_d = a_q - b_q;
      end else begin
        b_d = b_q - a_q;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_q <= '0;
      b_q <= '0;
      k_q <= '0;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
      k_q <= k_d;
    end
  end

endmodule

// File: rtl/gcd_engine.sv
// Binary (Stein) GCD engine: one algorithm step per clock.
// Ports:
//   Clk, rst          : clock, synchronous active-high reset
//   In_A, In_B        : unsigned operands, sampled on acceptance only
//   In_ready / In_ack : request handshake; acceptance when both are high
//   Result            : gcd(A, B), valid while Result_valid is high
//   Result_valid      : result held until an edge with Result_taken high
//   Result_taken      : consumer takes the result (ignored outside DONE)
//   Cycles            : edges spent in SHIFT + REDUCE, saturating
//   Err_zero          : both operands were zero
module gcd_engine
  import gcd_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CYC_W = 8
) (
  input  logic             Clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] In_A,
  input  logic [WIDTH-1:0] In_B,
  input  logic             In_ready,
  output logic             In_ack,
  output logic [WIDTH-1:0] Result,
  output logic             Result_valid,
  input  logic             Result_taken,
  output logic [CYC_W-1:0] Cycles,
  output logic             Err_zero
);

  localparam logic [CYC_W-1:0] CycOne = CYC_W'(1);

  gcd_state_e state_q, state_d;

  logic             accept;
  logic             in_shift;
  logic             in_reduce;
  logic             operand_zero;
  logic             both_even;
  logic             equal;
  logic [WIDTH-1:0] gcd_val;

  logic [WIDTH-1:0] result_q;
  logic [CYC_W-1:0] cycles_q;
  logic             err_zero_q;

  assign operand_zero = (In_A == '0) || (In_B == '0);

  gcd_datapath #(
    .Width (WIDTH)
  ) u_datapath (
    .clk_i       (Clk),
    .rst_i       (rst),
    .load_i      (accept),
    .a_i         (In_A),
    .b_i         (In_B),
    .shift_i     (in_shift),
    .reduce_i    (in_reduce),
    .both_even_o (both_even),
    .equal_o     (equal),
    .gcd_o       (gcd_val)
  );

  // State register
  always_ff @(posedge Clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) state_d = operand_zero ? StDone : StShift;
      end
      StShift: begin
        if (!both_even) state_d = StReduce;
      end
      StReduce: begin
        if (equal) state_d = StDone;
      end
      StDone: begin
        if (Result_taken) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Output / control decode
  always_comb begin
    In_ack       = (state_q == StIdle) && !rst;
    accept       = In_ack && In_ready;
    in_shift     = (state_q == StShift);
    in_reduce    = (state_q == StReduce);
    Result_valid = (state_q == StDone);
  end

  // Result, iteration counter and zero-operand flag
  always_ff @(posedge Clk) begin
    if (rst) begin
      result_q   <= '0;
      cycles_q   <= '0;
      err_zero_q <= 1'b0;
    end else if (accept) begin
      cycles_q   <= '0;
      err_zero_q <= (In_A == '0) && (In_B == '0);
      // A zero operand bypasses the algorithm: gcd(x, 0) = x.
      if (operand_zero) result_q <= In_A | In_B;
    end else if (in_shift || in_reduce) begin
      if (cycles_q != '1) cycles_q <= cycles_q + CycOne;
      if (in_reduce && equal) result_q <= gcd_val;
    end
  end

  assign Result   = result_q;
  assign Cycles   = cycles_q;
  assign Err_zero = err_zero_q;

endmodule

// File: tb/tb_gcd_engine.sv
module tb_gcd_engine;

  typedef struct {
    logic [7:0] res;
    int         cyc;  // -1 when not checked
    logic       err;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [7:0] in_a, in_b;
  logic       in_ready, in_ack;
  logic [7:0] result;
  logic       result_valid, result_taken;
  logic [7:0] cycles;
  logic       err_zero;
  logic       prev_v;
  logic       side_go;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  gcd_engine #(
    .WIDTH (8),
    .CYC_W (8)
  ) u_dut (
    .Clk          (clk),
    .rst          (rst),
    .In_A         (in_a),
    .In_B         (in_b),
    .In_ready     (in_ready),
    .In_ack       (in_ack),
    .Result       (result),
    .Result_valid (result_valid),
    .Result_taken (result_taken),
    .Cycles       (cycles),
    .Err_zero     (err_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Euclid by remainder: independent of the shift/subtract algorithm in the DUT.
  function automatic int unsigned ref_gcd(input int unsigned a, input int unsigned b);
    int unsigned x, y, t;
    x = a;
    y = b;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Scoreboard: pop one expectation on each rising Result_valid.
  always @(negedge clk) begin
    if (rst) begin
      prev_v <= 1'b0;
    end else begin
      prev_v <= result_valid;
      if (result_valid && !prev_v) begin
        if (sb.size() == 0) begin
          check_eq("sb_spurious", 32'(sb.size()), 1);
        end else begin
          check_eq("sb_result", result, sb[0].res);
          check_eq("sb_err_zero", err_zero, sb[0].err);
          if (sb[0].cyc >= 0) check_eq("sb_cycles", cycles, sb[0].cyc);
          void'(sb.pop_front());
        end
      end
    end
  end

  // One request: wait for ack, drive, wait for the result, optionally hold it, then take.
  // Latency is counted in edges after the acceptance edge and equals Cycles.
  task automatic do_req(input logic [7:0] a, input logic [7:0] b, input int exp_cyc,
                        input int hold, input bit busy);
    int   n;
    exp_t e;
    n = 0;
    while (!in_ack && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq("req_ack", in_ack, 1);
    e.res = 8'(ref_gcd(a, b));
    e.cyc = exp_cyc;
    e.err = (a == 0) && (b == 0);
    sb.push_back(e);
    in_a     = a;
    in_b     = b;
    in_ready = 1'b1;
    @(posedge clk);
    #1;
    in_ready = 1'b0;
    in_a     = 8'($urandom);
    in_b     = 8'($urandom);
    @(negedge clk);
    n = 0;
    while (!result_valid && n < 400) begin
      if (busy) begin
        in_ready     = ~in_ready;
        result_taken = ~result_taken;
        in_a         = 8'($urandom);
        in_b         = 8'($urandom);
      end
      @(negedge clk);
      n++;
    end
    in_ready     = 1'b0;
    result_taken = 1'b0;
    check_eq("valid_seen", result_valid, 1);
    if (exp_cyc >= 0) check_eq("latency", n, exp_cyc);
    for (int i = 0; i < hold; i++) begin
      in_ready = (i % 2 == 0);
      in_a     = 8'($urandom);
      @(negedge clk);
      check_eq("hold_valid", result_valid, 1);
      check_eq("hold_result", result, e.res);
      check_eq("hold_ack", in_ack, 0);
      if (exp_cyc >= 0) check_eq("hold_cycles", cycles, exp_cyc);
    end
    in_ready     = 1'b0;
    result_taken = 1'b1;
    @(negedge clk);
    result_taken = 1'b0;
    check_eq("take_ack", in_ack, 1);
    check_eq("take_valid", result_valid, 0);
  endtask

  // Random-only engines at other widths.
  for (genvar gi = 0; gi < 2; gi++) begin : gen_w
    localparam int W = (gi == 0) ? 4 : 16;
    logic [W-1:0] a, b, res;
    logic         rdy, ack, vld, tkn, ez;
    logic [7:0]   cyc;
    bit           done = 1'b0;
    logic [W-1:0] exp_q[$];

    gcd_engine #(
      .WIDTH (W),
      .CYC_W (8)
    ) u_dut (
      .Clk          (clk),
      .rst          (rst),
      .In_A         (a),
      .In_B         (b),
      .In_ready     (rdy),
      .In_ack       (ack),
      .Result       (res),
      .Result_valid (vld),
      .Result_taken (tkn),
      .Cycles       (cyc),
      .Err_zero     (ez)
    );

    initial begin : drive
      logic [W-1:0] ea, eb;
      int           n;
      rdy = 1'b0;
      tkn = 1'b0;
      a   = '0;
      b   = '0;
      wait (side_go);
      @(negedge clk);
      for (int i = 0; i < 30; i++) begin
        ea = (i % 10 == 4) ? '0 : W'($urandom);
        eb = (i % 10 == 7) ? '0 : W'($urandom);
        n = 0;
        while (!ack && n < 100) begin
          @(negedge clk);
          n++;
        end
        check_eq($sformatf("w%0d_ack", W), ack, 1);
        exp_q.push_back(W'(ref_gcd(ea, eb)));
        a   = ea;
        b   = eb;
        rdy = 1'b1;
        @(negedge clk);
        rdy = 1'b0;
        a   = W'($urandom);
        b   = W'($urandom);
        n = 0;
        while (!vld && n < 500) begin
          @(negedge clk);
          n++;
        end
        check_eq($sformatf("w%0d_valid", W), vld, 1);
        check_eq($sformatf("w%0d_result", W), res, exp_q[0]);
        check_eq($sformatf("w%0d_err_zero", W), ez, (ea == 0) && (eb == 0));
        void'(exp_q.pop_front());
        tkn = 1'b1;
        @(negedge clk);
        tkn = 1'b0;
      end
      done = 1'b1;
    end
  end

  initial begin : main
    int         n;
    logic [7:0] ra, rb;
    rst          = 1'b1;
    in_a         = '0;
    in_b         = '0;
    in_ready     = 1'b0;
    result_taken = 1'b0;
    side_go      = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_valid", result_valid, 0);
    check_eq("rst_result", result, 0);
    check_eq("rst_cycles", cycles, 0);
    check_eq("rst_err_zero", err_zero, 0);
    check_eq("rst_ack_low", in_ack, 0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("ack_after_rst", in_ack, 1);

    // Take while idle is ignored
    result_taken = 1'b1;
    @(negedge clk);
    result_taken = 1'b0;
    check_eq("idle_take_ack", in_ack, 1);
    check_eq("idle_take_valid", result_valid, 0);

    do_req(8'd12, 8'd18, 6, 0, 1'b0);
    do_req(8'd7, 8'd7, 2, 0, 1'b0);
    do_req(8'd255, 8'd255, 2, 0, 1'b0);
    do_req(8'd5, 8'd0, 0, 0, 1'b0);
    do_req(8'd0, 8'd0, 0, 0, 1'b0);
    do_req(8'd12, 8'd18, 6, 10, 1'b1);

    // Reset during REDUCE for 200,120: three shifts, exit edge, then REDUCE.
    n = 0;
    while (!in_ack && n < 100) begin
      @(negedge clk);
      n++;
    end
    in_a     = 8'd200;
    in_b     = 8'd120;
    in_ready = 1'b1;
    @(posedge clk);
    #1;
    in_ready = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("midrst_valid", result_valid, 0);
    check_eq("midrst_result", result, 0);
    check_eq("midrst_cycles", cycles, 0);
    check_eq("midrst_err_zero", err_zero, 0);
    check_eq("midrst_ack", in_ack, 0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("midrst_ack_after", in_ack, 1);
    do_req(8'd200, 8'd120, 9, 0, 1'b0);

    // Random back-to-back requests, taken on the first valid edge
    for (int i = 0; i < 40; i++) begin
      ra = (i % 8 == 3) ? 8'd0 : 8'($urandom_range(1, 255));
      rb = (i % 8 == 5) ? 8'd0 : 8'($urandom_range(1, 255));
      do_req(ra, rb, ((ra == 0) || (rb == 0)) ? 0 : -1, 0, 1'b0);
    end
    check_eq("sb_drained", 32'(sb.size()), 0);

    side_go = 1'b1;
    n = 0;
    while (!(gen_w[0].done && gen_w[1].done) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check_eq("side_done", gen_w[0].done && gen_w[1].done, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
